// File: rtl/add64_sched_pkg.sv
// Shared types and constants for the two-pass 64-bit add scheduler.
package add64_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int HALF_W = 32;
  localparam int FULL_W = 64;

  typedef logic req_id_t;

endpackage

// File: rtl/adder32.sv
// 32-bit ripple-carry adder shared by both halves of a 64-bit add.
module adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] s,
  output logic        cout
);

  logic carry;

  always_comb begin
    carry = cin;
    s     = '0;
    for (int i = 0; i < 32; i++) begin
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/add64_sched.sv
// Round-robin arbiter that runs 64-bit adds from two requesters through one
// 32-bit adder in two passes (low half, then high half with forwarded carry).
module add64_sched #(
  parameter int HALF_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [2*HALF_W-1:0]   req0_a,
  input  logic [2*HALF_W-1:0]   req0_b,
  input  logic                  req0_cin,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [2*HALF_W-1:0]   req1_a,
  input  logic [2*HALF_W-1:0]   req1_b,
  input  logic                  req1_cin,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [2*HALF_W-1:0]   rsp_s,
  output logic                  rsp_cout,
  output logic                  busy,
  output logic [CNT_W-1:0]      ops_count
);
  import add64_sched_pkg::*;

  state_t                state_reg, state_next;
  logic [2*HALF_W-1:0]   a_reg, b_reg;
  logic                  cin_reg;
  req_id_t               id_reg, last_id_reg, grant;
  logic [HALF_W-1:0]     s_lo_reg;
  logic                  c_mid_reg;
  logic                  rsp_valid_reg, rsp_cout_reg;
  req_id_t               rsp_id_reg;
  logic [2*HALF_W-1:0]   rsp_s_reg;
  logic [CNT_W-1:0]      ops_count_reg;
  logic                  accept;
  logic [HALF_W-1:0]     add_a, add_b, add_s;
  logic                  add_cin, add_cout;

  adder32 u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .s    (add_s),
    .cout (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    // When both are pending, the one that was not served last wins.
    if (req0_valid && req1_valid) grant = ~last_id_reg;
    else                          grant = req1_valid;
    req0_ready = (state_reg == IDLE) && req0_valid && (grant == 1'b0);
    req1_ready = (state_reg == IDLE) && req1_valid && (grant == 1'b1);
    accept     = req0_ready | req1_ready;
    add_a      = a_reg[HALF_W-1:0];
    add_b      = b_reg[HALF_W-1:0];
    add_cin    = cin_reg;
    case (state_reg)
      IDLE: if (accept) state_next = LO;
      LO:   state_next = HI;
      HI: begin
        add_a      = a_reg[2*HALF_W-1:HALF_W];
        add_b      = b_reg[2*HALF_W-1:HALF_W];
        add_cin    = c_mid_reg;
        state_next = DONE;
      end
      DONE: if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg         <= '0;
      b_reg         <= '0;
      cin_reg       <= 1'b0;
      id_reg        <= 1'b0;
      last_id_reg   <= 1'b1;
      s_lo_reg      <= '0;
      c_mid_reg     <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= 1'b0;
      rsp_s_reg     <= '0;
      rsp_cout_reg  <= 1'b0;
      ops_count_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: if (accept) begin
          a_reg   <= grant ? req1_a   : req0_a;
          b_reg   <= grant ? req1_b   : req0_b;
          cin_reg <= grant ? req1_cin : req0_cin;
          id_reg  <= grant;
        end
        LO: begin
          s_lo_reg  <= add_s;
          c_mid_reg <= add_cout;
        end
        HI: begin
          rsp_s_reg     <= {add_s, s_lo_reg};
          rsp_cout_reg  <= add_cout;
          rsp_id_reg    <= id_reg;
          rsp_valid_reg <= 1'b1;
        end
        DONE: if (rsp_ready) begin
          rsp_valid_reg <= 1'b0;
          last_id_reg   <= rsp_id_reg;
          ops_count_reg <= ops_count_reg + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_s     = rsp_s_reg;
  assign rsp_cout  = rsp_cout_reg;
  assign busy      = (state_reg != IDLE);
  assign ops_count = ops_count_reg;

endmodule

// File: tb/tb_add64_sched.sv
// Directed table-driven bench for add64_sched, plus hand-written sequences for
// contention, back-pressure, mid-operation reset and counter wrap.
module tb_add64_sched;

  localparam int CW = 4;

  logic          clk, rst_n;
  logic          req0_valid, req0_ready, req0_cin;
  logic [63:0]   req0_a, req0_b;
  logic          req1_valid, req1_ready, req1_cin;
  logic [63:0]   req1_a, req1_b;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_cout, busy;
  logic [63:0]   rsp_s;
  logic [CW-1:0] ops_count;

  add64_sched #(.HALF_W(32), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_cin(req1_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_s(rsp_s), .rsp_cout(rsp_cout), .busy(busy), .ops_count(ops_count)
  );

  typedef struct {
    bit          id;
    logic [63:0] a;
    logic [63:0] b;
    bit          cin;
    logic [63:0] exp_s;
    bit          exp_cout;
  } vec_t;

  vec_t vecs [8];
  int   checks = 0;
  int   failures = 0;
  int   exp_ops = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    if (v.id == 1'b0) begin
      req0_valid = 1'b1; req0_a = v.a; req0_b = v.b; req0_cin = v.cin;
    end else begin
      req1_valid = 1'b1; req1_a = v.a; req1_b = v.b; req1_cin = v.cin;
    end
  endtask

  // Runs one isolated op with rsp_ready high; entered and left just after an edge.
  task automatic do_op(input int vi);
    vec_t v;
    int   lat;
    v = vecs[vi];
    rsp_ready = 1'b1;
    drive(v);
    #1;
    chk("ready_own", v.id ? req1_ready : req0_ready, 1);
    chk("ready_other", v.id ? req0_ready : req1_ready, 0);
    step;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      step;
      lat++;
    end
    // Edges from the handshake edge to rsp_valid: accept->LO, LO->HI, HI->DONE.
    chk("latency_edges", lat, 3);
    chk("rsp_s", rsp_s, v.exp_s);
    chk("rsp_cout", rsp_cout, v.exp_cout);
    chk("rsp_id", rsp_id, v.id);
    chk("busy_done", busy, 1);
    $display("op vec=%0d id=%0d a=%h b=%h cin=%0d -> s=%h cout=%0d", vi, rsp_id, v.a, v.b, v.cin, rsp_s, rsp_cout);
    step;
    exp_ops++;
    chk("rsp_valid_clear", rsp_valid, 0);
    chk("ops_count", ops_count, exp_ops % (1 << CW));
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    int   grants [$];
    int   nrsp;
    logic [63:0] held_s;

    vecs[0] = '{0, 64'h00000000_FFFFFFFF, 64'h1, 0, 64'h00000001_00000000, 0};
    vecs[1] = '{1, 64'hFFFFFFFF_FFFFFFFF, 64'h0, 1, 64'h0, 1};
    vecs[2] = '{0, 64'h80000000_00000000, 64'h80000000_00000000, 0, 64'h0, 1};
    vecs[3] = '{1, 64'h12345678_9ABCDEF0, 64'h11111111_11111111, 0, 64'h23456789_ABCDF001, 0};
    vecs[4] = '{0, 64'h00000000_80000000, 64'h00000000_80000000, 1, 64'h00000001_00000001, 0};
    vecs[5] = '{1, 64'h7FFFFFFF_FFFFFFFF, 64'h1, 0, 64'h80000000_00000000, 0};
    vecs[6] = '{0, 64'h0, 64'h0, 1, 64'h1, 0};
    vecs[7] = '{1, 64'hFFFFFFFF_00000000, 64'h00000001_00000000, 1, 64'h00000000_00000001, 1};

    rst_n = 1'b0;
    rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    #12;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_s", rsp_s, 0);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_busy", busy, 0);
    chk("reset_ops_count", ops_count, 0);
    step;
    rst_n = 1'b1;
    step;

    do_op(0);
    do_op(1);

    // Contention: both held valid, expect alternating grants starting at 0.
    drive(vecs[2]);
    drive(vecs[3]);
    nrsp = 0;
    for (int cyc = 0; cyc < 60 && nrsp < 4; cyc++) begin
      #1;
      chk("ready_exclusive", req0_ready & req1_ready, 0);
      if (req0_ready) grants.push_back(0);
      if (req1_ready) grants.push_back(1);
      if (rsp_valid) begin
        chk("cont_id", rsp_id, grants[nrsp]);
        chk("cont_s", rsp_s, rsp_id ? vecs[3].exp_s : vecs[2].exp_s);
        chk("cont_cout", rsp_cout, rsp_id ? vecs[3].exp_cout : vecs[2].exp_cout);
        $display("op contention n=%0d id=%0d s=%h cout=%0d", nrsp, rsp_id, rsp_s, rsp_cout);
        nrsp++;
        exp_ops++;
        if (nrsp == 4) begin
          req0_valid = 1'b0;
          req1_valid = 1'b0;
        end
      end
      @(posedge clk);
    end
    #1;
    chk("cont_count", nrsp, 4);
    chk("cont_grants", grants.size(), 4);
    for (int i = 0; i < grants.size() && i < 4; i++) chk("cont_order", grants[i], i % 2);
    chk("cont_ops_count", ops_count, exp_ops % (1 << CW));

    // Back-pressure: result held while rsp_ready is low; later operand changes ignored.
    rsp_ready = 1'b0;
    drive(vecs[4]);
    drive(vecs[5]);
    #1;
    chk("bp_grant0", req0_ready, 1);
    step;
    req0_a = 64'hDEADBEEF_DEADBEEF;
    begin
      int w;
      w = 0;
      while (!rsp_valid && w < 10) begin step; w++; end
      chk("bp_rsp_seen", rsp_valid, 1);
    end
    held_s = rsp_s;
    chk("bp_s", rsp_s, vecs[4].exp_s);
    for (int i = 0; i < 5; i++) begin
      step;
      chk("bp_valid_hold", rsp_valid, 1);
      chk("bp_s_hold", rsp_s, held_s);
      chk("bp_busy", busy, 1);
      chk("bp_no_ready", req0_ready | req1_ready, 0);
    end
    $display("op backpressure id=%0d s=%h cout=%0d", rsp_id, rsp_s, rsp_cout);
    rsp_ready = 1'b1;
    step;
    exp_ops++;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("bp_release_valid", rsp_valid, 0);
    chk("bp_release_count", ops_count, exp_ops % (1 << CW));
    step;
    chk("bp_single_handoff", busy, 0);

    for (int i = 5; i < 8; i++) do_op(i);

    // Reset during the HI pass abandons the op.
    drive(vecs[6]);
    #1;
    chk("rst_mid_ready", req0_ready, 1);
    step;
    req0_valid = 1'b0;
    step;
    chk("rst_mid_busy_hi", busy, 1);
    rst_n = 1'b0;
    #1;
    exp_ops = 0;
    chk("rst_mid_valid", rsp_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ops", ops_count, 0);
    chk("rst_mid_s", rsp_s, 0);
    chk("rst_mid_cout", rsp_cout, 0);
    step;
    step;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step;
      chk("rst_mid_no_rsp", rsp_valid, 0);
    end
    do_op(0);

    // Counter wrap with the narrow counter instance.
    while (exp_ops < (1 << CW)) do_op(exp_ops % 8);
    chk("wrap_zero", ops_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
